ad7124_conv_sequencer: RTL and testbench
========================================

# ad7124_conv_sequencer

Command sequencer that drives the AD7124 SPI transaction engine on its command side and consumes its read results. It polls the ADC STATUS register and reads DATA when RDY is asserted. Each conversion result is presented with its channel number on a valid/ready sample port toward the capture/AXI logic. It sits directly upstream of the SPI engine: `spi_cmd`/`spi_cmd_vld` feed its command inputs, and `spi_rd_data`/`spi_rd_vld` take its 24-bit result and done pulse.

## Interface
Parameters:
- `DATA_WD`, 24: width of one SPI read result.
- `CMD_WD`, 8: command byte width.
- `POLL_DIV`, 4000: clk cycles between STATUS polls; minimum 1.
- `RESP_TO`, 4096: clk cycles allowed from command issue to `spi_rd_vld`.
- `RDY_TO_POLLS`, 1024: consecutive not-ready polls before a ready timeout.

Ports:
- `clk` in 1: single clock, shared with the SPI engine.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; run continuous acquisition.
- `clr_flags` in 1: pulse; clears the sticky flags.
- `spi_cmd` out `CMD_WD`: command byte to the SPI engine.
- `spi_cmd_vld` out 1: one-cycle command strobe.
- `spi_rd_data` in `DATA_WD`: read result from the SPI engine.
- `spi_rd_vld` in 1: one-cycle result strobe.
- `smp_data` out 24: conversion result.
- `smp_chan` out 4: channel number taken from STATUS[3:0].
- `smp_valid` out 1; `smp_ready` in 1: sample handshake.
- `busy` out 1: high when the state is not IDLE.
- `err_resp` out 1: sticky; SPI response timeout.
- `err_rdy` out 1: sticky; RDY timeout.
- `err_ovr` out 1: sticky; sample overrun.

## Operation
- States: IDLE, WAIT_POLL, ISSUE_STAT, WAIT_STAT, ISSUE_DATA, WAIT_DATA.
- IDLE:
  - `enable` = 1 → WAIT_POLL.
  - The poll counter loads `POLL_DIV-1`.
- WAIT_POLL:
  - Down-counts the poll counter.
  - At 0 → ISSUE_STAT.
  - If `enable` = 0 → IDLE.
- ISSUE_STAT:
  - `spi_cmd` = 8'h40 (read, addr 0x00).
  - `spi_cmd_vld` = 1 for this cycle only.
  - → WAIT_STAT.
- WAIT_STAT, on `spi_rd_vld`:
  - status = `spi_rd_data[23:16]`.
  - status[7] = 0 (RDY): latch `status[3:0]` into the channel register, clear the not-ready count, → ISSUE_DATA.
  - status[7] = 1: increment the not-ready count, → WAIT_POLL.
  - When the count reaches `RDY_TO_POLLS`: set `err_rdy`, clear the count, continue polling.
- ISSUE_DATA:
  - `spi_cmd` = 8'h42 (read, addr 0x02).
  - One-cycle `spi_cmd_vld`.
  - → WAIT_DATA.
- WAIT_DATA, on `spi_rd_vld`:
  - Capture `spi_rd_data[23:0]`.
  - Apply the push rule below.
  - → WAIT_POLL.
- Response timeout:
  - In WAIT_STAT/WAIT_DATA, the response counter counts from issue.
  - Reaching `RESP_TO` with no `spi_rd_vld`: set `err_resp`, → WAIT_POLL.
  - A late `spi_rd_vld` arriving in any other state is ignored.
- Push rule:
  - If `smp_valid` = 0, or `smp_ready` = 1 in the same cycle: load `smp_data`/`smp_chan` and set `smp_valid`.
  - Otherwise: drop the new sample, keep the held sample unchanged, set `err_ovr`.
- `smp_valid` clears on `smp_valid & smp_ready` unless a push happens in the same cycle.
- `enable` deasserted mid-transaction: the current SPI transaction completes (the engine cannot abort), then → IDLE. A completed DATA read is still pushed.
- `clr_flags` together with a setting event in the same cycle: the set wins.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - `spi_cmd` 8'h00, `spi_cmd_vld` 0.
  - `smp_data` 0, `smp_chan` 0, `smp_valid` 0.
  - `busy` 0; `err_*` 0.
- All outputs are registered.
- `spi_cmd` is driven in the same cycle as `spi_cmd_vld` and held until the next issue.
- Latency:
  - `spi_rd_vld` of a DATA read → `smp_valid` high on the next cycle.
  - `enable` rise → first `spi_cmd_vld` after `POLL_DIV`+1 cycles.
- At most one command is outstanding; `spi_cmd_vld` is never asserted in WAIT_STAT/WAIT_DATA.
- `rst` mid-operation: returns to IDLE in one cycle; the SPI engine must be reset in the same cycle.

## Configuration
- `AD7124_SEQ_TWOS_COMP_EN` defined: `smp_data` = {~d[23], d[22:0]}, converting bipolar offset-binary to two's complement.
- Not defined: `smp_data` = raw d[23:0].

## Structure
- Shared package `ad7124_pkg`:
  - state enum.
  - command constants `AD7124_CMD_RD_STATUS` = 8'h40 and `AD7124_CMD_RD_DATA` = 8'h42.
  - status field positions (RDY bit 7, CH [3:0]).
- One natural sub-module: `ad7124_sample_reg`, the output register with push/ovr logic and the optional two's complement conversion.

## Test plan
- `POLL_DIV`=4; `enable`=1; STATUS response 24'h03_0000 (RDY, ch 3), then DATA 24'h800001 → `spi_cmd` sequence 40,42; `smp_valid` with `smp_data` 800001 (raw) or 000001 (with macro), `smp_chan`=3.
- STATUS returns 24'h80_0000 for `RDY_TO_POLLS`=3 consecutive polls → `err_rdy` set after the 3rd response; polling continues; `clr_flags` → 0.
- Suppress `spi_rd_vld` after 8'h40 with `RESP_TO`=16 → `err_resp` high 16 cycles after issue; the next `spi_cmd_vld` is 8'h40 after `POLL_DIV`.
- Hold `smp_ready`=0 across two DATA reads (A, then B) → `smp_data` stays A; `err_ovr`=1; `smp_ready`=1 → A accepted, `smp_valid`=0.
- Deassert `enable` in WAIT_DATA → the sample is still pushed, then IDLE, `busy`=0, no further `spi_cmd_vld`.
- Assert `rst` in WAIT_STAT → next cycle all outputs at reset values; a subsequent `spi_rd_vld` is ignored.

Source files
------------

// File: rtl/ad7124_pkg.sv
// Shared definitions for the AD7124 conversion sequencer: FSM state
// encoding, SPI command bytes and STATUS register field positions.
package ad7124_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_POLL  = 3'd1,
      ST_ISSUE_STAT = 3'd2,
      ST_WAIT_STAT  = 3'd3,
      ST_ISSUE_DATA = 3'd4,
      ST_WAIT_DATA  = 3'd5
   } seq_state_e;

   // Read commands: bit 6 set selects a register read, low bits are the address.
   localparam logic [7:0] AD7124_CMD_RD_STATUS = 8'h40;
   localparam logic [7:0] AD7124_CMD_RD_DATA   = 8'h42;

   // The 8-bit STATUS value arrives in the top byte of the 24-bit read result.
   localparam int STAT_LSB     = 16;
   localparam int STAT_RDY_BIT = 7;   // 0 = conversion ready
   localparam int STAT_CH_LSB  = 0;
   localparam int STAT_CH_W    = 4;

endpackage

// File: rtl/ad7124_sample_reg.sv
// Output sample register: valid/ready holding stage with overrun detection.
// Optional feature macro AD7124_SEQ_TWOS_COMP_EN: when defined, the loaded
// sample is converted from bipolar offset-binary to two's complement.
module ad7124_sample_reg
   import ad7124_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_i,
   input  logic [23:0]          push_data_i,
   input  logic [STAT_CH_W-1:0] push_chan_i,
   input  logic                 smp_ready_i,
   input  logic                 clr_flags_i,
   output logic [23:0]          smp_data_o,
   output logic [STAT_CH_W-1:0] smp_chan_o,
   output logic                 smp_valid_o,
   output logic                 err_ovr_o
);

   logic [23:0]          data_q, data_d;
   logic [STAT_CH_W-1:0] chan_q, chan_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 load;

   function automatic logic [23:0] conv_sample(input logic [23:0] d);
`ifdef AD7124_SEQ_TWOS_COMP_EN
      return {~d[23], d[22:0]};
`else
      return d;
`endif
   endfunction

   // A new sample may enter only if the slot is empty or being drained now.
   assign load = push_i & (~valid_q | smp_ready_i);

   // Next-state for the holding register and the sticky overrun flag.
   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (clr_flags_i) ovr_d = 1'b0;
      if (push_i && !load) ovr_d = 1'b1;   // set beats a simultaneous clear
      if (valid_q && smp_ready_i) valid_d = 1'b0;
      if (load) begin
         data_d  = conv_sample(push_data_i);
         chan_d  = push_chan_i;
         valid_d = 1'b1;
      end
   end

   // Register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign smp_data_o  = data_q;
   assign smp_chan_o  = chan_q;
   assign smp_valid_o = valid_q;
   assign err_ovr_o   = ovr_q;

endmodule

// File: rtl/ad7124_conv_sequencer.sv
// AD7124 conversion sequencer: polls STATUS at a fixed interval, reads DATA
// once RDY is low and hands each result with its channel to the sample port.
// Optional feature macro AD7124_SEQ_TWOS_COMP_EN (see ad7124_sample_reg).
module ad7124_conv_sequencer #(
   parameter int DATA_WD      = 24,
   parameter int CMD_WD       = 8,
   parameter int POLL_DIV     = 4000,
   parameter int RESP_TO      = 4096,
   parameter int RDY_TO_POLLS = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               clr_flags,
   output logic [CMD_WD-1:0]  spi_cmd,
   output logic               spi_cmd_vld,
   input  logic [DATA_WD-1:0] spi_rd_data,
   input  logic               spi_rd_vld,
   output logic [23:0]        smp_data,
   output logic [3:0]         smp_chan,
   output logic               smp_valid,
   input  logic               smp_ready,
   output logic               busy,
   output logic               err_resp,
   output logic               err_rdy,
   output logic               err_ovr
);

   import ad7124_pkg::*;

   localparam int PW = $clog2(POLL_DIV + 1);
   localparam int RW = $clog2(RESP_TO + 1);
   localparam int NW = $clog2(RDY_TO_POLLS + 1);

   seq_state_e           state_q, state_d;
   logic [PW-1:0]        poll_q, poll_d;
   logic [RW-1:0]        resp_q, resp_d;
   logic [NW-1:0]        nrdy_q, nrdy_d;
   logic [STAT_CH_W-1:0] chan_q, chan_d;
   logic [CMD_WD-1:0]    spi_cmd_q, spi_cmd_d;
   logic                 cmd_vld_q, cmd_vld_d;
   logic                 busy_q, busy_d;
   logic                 err_resp_q, err_resp_d;
   logic                 err_rdy_q, err_rdy_d;
   logic                 waiting, expire, stat_rdy, push;

   assign waiting  = (state_q == ST_WAIT_STAT) || (state_q == ST_WAIT_DATA);
   // Last cycle of the response window; a strobe in this cycle still counts.
   assign expire   = waiting && (resp_q >= RW'(RESP_TO - 1));
   assign stat_rdy = ~spi_rd_data[STAT_LSB + STAT_RDY_BIT];
   assign push     = (state_q == ST_WAIT_DATA) && spi_rd_vld;

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         poll_q     <= '0;
         resp_q     <= '0;
         nrdy_q     <= '0;
         chan_q     <= '0;
         spi_cmd_q  <= '0;
         cmd_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_resp_q <= 1'b0;
         err_rdy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         poll_q     <= poll_d;
         resp_q     <= resp_d;
         nrdy_q     <= nrdy_d;
         chan_q     <= chan_d;
         spi_cmd_q  <= spi_cmd_d;
         cmd_vld_q  <= cmd_vld_d;
         busy_q     <= busy_d;
         err_resp_q <= err_resp_d;
         err_rdy_q  <= err_rdy_d;
      end
   end

   // Next-state logic; an issued transaction always runs to its end before IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (enable) state_d = ST_WAIT_POLL;
         ST_WAIT_POLL: begin
            if (!enable)          state_d = ST_IDLE;
            else if (poll_q == '0) state_d = ST_ISSUE_STAT;
         end
         ST_ISSUE_STAT: state_d = ST_WAIT_STAT;
         ST_WAIT_STAT: begin
            if (spi_rd_vld) begin
               if (!enable)       state_d = ST_IDLE;
               else if (stat_rdy) state_d = ST_ISSUE_DATA;
               else               state_d = ST_WAIT_POLL;
            end else if (expire) begin
               state_d = enable ? ST_WAIT_POLL : ST_IDLE;
            end
         end
         ST_ISSUE_DATA: state_d = ST_WAIT_DATA;
         ST_WAIT_DATA: begin
            if (spi_rd_vld || expire) state_d = enable ? ST_WAIT_POLL : ST_IDLE;
         end
         default:       state_d = ST_IDLE;
      endcase
   end

   // Output next values: the strobe tracks the ISSUE states, the byte is held.
   always_comb begin
      spi_cmd_d = spi_cmd_q;
      cmd_vld_d = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      if (state_d == ST_ISSUE_STAT) begin
         spi_cmd_d = CMD_WD'(AD7124_CMD_RD_STATUS);
         cmd_vld_d = 1'b1;
      end else if (state_d == ST_ISSUE_DATA) begin
         spi_cmd_d = CMD_WD'(AD7124_CMD_RD_DATA);
         cmd_vld_d = 1'b1;
      end
   end

   // Poll/response/not-ready counters, channel capture and sticky flags.
   always_comb begin
      poll_d     = (state_q == ST_WAIT_POLL && poll_q != '0) ? poll_q - 1'b1
                                                             : PW'(POLL_DIV - 1);
      resp_d     = '0;
      nrdy_d     = nrdy_q;
      chan_d     = chan_q;
      err_resp_d = err_resp_q;
      err_rdy_d  = err_rdy_q;
      if (clr_flags) begin
         err_resp_d = 1'b0;
         err_rdy_d  = 1'b0;
      end
      if (state_q == ST_ISSUE_STAT || state_q == ST_ISSUE_DATA) resp_d = RW'(1);
      else if (waiting) resp_d = resp_q + 1'b1;
      if (waiting && expire && !spi_rd_vld) err_resp_d = 1'b1;
      if (state_q == ST_WAIT_STAT && spi_rd_vld) begin
         if (stat_rdy) begin
            chan_d = spi_rd_data[STAT_LSB + STAT_CH_LSB +: STAT_CH_W];
            nrdy_d = '0;
         end else if (nrdy_q == NW'(RDY_TO_POLLS - 1)) begin
            err_rdy_d = 1'b1;
            nrdy_d    = '0;
         end else begin
            nrdy_d = nrdy_q + 1'b1;
         end
      end
   end

   ad7124_sample_reg u_sample_reg (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (spi_rd_data[23:0]),
      .push_chan_i (chan_q),
      .smp_ready_i (smp_ready),
      .clr_flags_i (clr_flags),
      .smp_data_o  (smp_data),
      .smp_chan_o  (smp_chan),
      .smp_valid_o (smp_valid),
      .err_ovr_o   (err_ovr)
   );

   assign spi_cmd     = spi_cmd_q;
   assign spi_cmd_vld = cmd_vld_q;
   assign busy        = busy_q;
   assign err_resp    = err_resp_q;
   assign err_rdy     = err_rdy_q;

endmodule

// File: tb/tb_ad7124_conv_sequencer.sv
// Directed bench for ad7124_conv_sequencer with command/sample scoreboards.
module tb_ad7124_conv_sequencer;

   localparam int POLL_DIV = 4;
   localparam int RESP_TO  = 16;
   localparam int RDY_TO   = 3;

   logic        clk = 1'b0;
   logic        rst, enable, clr_flags, spi_rd_vld, smp_ready;
   logic [23:0] spi_rd_data;
   logic [7:0]  spi_cmd;
   logic        spi_cmd_vld, smp_valid, busy, err_resp, err_rdy, err_ovr;
   logic [23:0] smp_data;
   logic [3:0]  smp_chan;

   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_cmd_q[$];
   logic [27:0] exp_smp_q[$];   // {chan, data}

   ad7124_conv_sequencer #(
      .DATA_WD(24), .CMD_WD(8), .POLL_DIV(POLL_DIV), .RESP_TO(RESP_TO),
      .RDY_TO_POLLS(RDY_TO)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags),
      .spi_cmd(spi_cmd), .spi_cmd_vld(spi_cmd_vld),
      .spi_rd_data(spi_rd_data), .spi_rd_vld(spi_rd_vld),
      .smp_data(smp_data), .smp_chan(smp_chan), .smp_valid(smp_valid),
      .smp_ready(smp_ready), .busy(busy), .err_resp(err_resp),
      .err_rdy(err_rdy), .err_ovr(err_ovr)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] tc(input logic [23:0] d);
`ifdef AD7124_SEQ_TWOS_COMP_EN
      return {~d[23], d[22:0]};
`else
      return d;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_spi_cmd"}, spi_cmd, 0);
      chk({tag, "_cmd_vld"}, spi_cmd_vld, 0);
      chk({tag, "_smp_data"}, smp_data, 0);
      chk({tag, "_smp_chan"}, smp_chan, 0);
      chk({tag, "_smp_valid"}, smp_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_errs"}, {err_resp, err_rdy, err_ovr}, 0);
   endtask

   // Scoreboard: every command strobe and every accepted sample is popped and compared.
   always @(negedge clk) begin
      if (spi_cmd_vld) begin
         checks++;
         assert (exp_cmd_q.size() != 0) else begin
            errors++;
            $error("FAIL cmd_unexpected: observed %0h expected none", spi_cmd);
         end
         if (exp_cmd_q.size() != 0) chk("cmd_byte", spi_cmd, exp_cmd_q.pop_front());
      end
      if (smp_valid && smp_ready) begin
         checks++;
         assert (exp_smp_q.size() != 0) else begin
            errors++;
            $error("FAIL smp_unexpected: observed %0h expected none", smp_data);
         end
         if (exp_smp_q.size() != 0) chk("smp_accept", {smp_chan, smp_data}, exp_smp_q.pop_front());
      end
   end

   task automatic wait_cmd();
      int n = 0;
      @(negedge clk);
      while (!spi_cmd_vld && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_wait", spi_cmd_vld, 1);
   endtask

   task automatic respond(input logic [23:0] d, input bit nxt, input logic [7:0] c);
      @(posedge clk); #1;
      @(posedge clk); #1;
      spi_rd_data = d;
      spi_rd_vld  = 1'b1;
      if (nxt) exp_cmd_q.push_back(c);
      @(posedge clk); #1;
      spi_rd_vld  = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1; clr_flags = 1'b1;
      @(posedge clk); #1; clr_flags = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; enable = 1'b0; clr_flags = 1'b0;
      spi_rd_vld = 1'b0; spi_rd_data = '0; smp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(posedge clk); #1; rst = 1'b0;

      // Basic conversion: STATUS ready on channel 3, then DATA.
      smp_ready = 1'b1;
      enable = 1'b1;
      exp_cmd_q.push_back(8'h40);
      n = 0;
      while (!spi_cmd_vld && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("first_cmd_latency", n, POLL_DIV + 1);
      chk("busy_running", busy, 1);
      respond(24'h03_0000, 1, 8'h42);
      wait_cmd();
      exp_smp_q.push_back({4'd3, tc(24'h800001)});
      respond(24'h800001, 1, 8'h40);
      chk("smp_latency", smp_valid, 1);
      chk("smp_data_a", smp_data, tc(24'h800001));
      chk("smp_chan_a", smp_chan, 3);

      // RDY timeout after three not-ready polls.
      wait_cmd();
      respond(24'h80_0000, 1, 8'h40);
      chk("err_rdy_1", err_rdy, 0);
      wait_cmd();
      respond(24'h80_0000, 1, 8'h40);
      chk("err_rdy_2", err_rdy, 0);
      wait_cmd();
      respond(24'h80_0000, 1, 8'h40);
      chk("err_rdy_3", err_rdy, 1);
      wait_cmd();
      pulse_clr();
      chk("err_rdy_clr", err_rdy, 0);
      respond(24'h80_0000, 1, 8'h40);

      // Response timeout: no reply to this STATUS read.
      wait_cmd();
      exp_cmd_q.push_back(8'h40);
      n = 0;
      while (!err_resp && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("err_resp_latency", n, RESP_TO);
      n = 0;
      while (!spi_cmd_vld && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("repoll_latency", n, POLL_DIV);

      // Overrun: two DATA reads while the consumer stalls.
      smp_ready = 1'b0;
      respond(24'h05_0000, 1, 8'h42);
      wait_cmd();
      exp_smp_q.push_back({4'd5, tc(24'h123456)});
      respond(24'h123456, 1, 8'h40);
      chk("ovr_a_valid", smp_valid, 1);
      chk("ovr_a_noerr", err_ovr, 0);
      wait_cmd();
      respond(24'h07_0000, 1, 8'h42);
      wait_cmd();
      respond(24'hABCDEF, 1, 8'h40);
      chk("ovr_hold_data", smp_data, tc(24'h123456));
      chk("ovr_hold_chan", smp_chan, 5);
      chk("ovr_flag", err_ovr, 1);
      chk("ovr_still_valid", smp_valid, 1);
      @(posedge clk); #1; smp_ready = 1'b1;
      @(posedge clk); #1; smp_ready = 1'b0;
      chk("ovr_drained", smp_valid, 0);
      wait_cmd();
      pulse_clr();
      chk("clr_ovr", err_ovr, 0);
      chk("clr_resp", err_resp, 0);

      // Disable while a DATA read is outstanding.
      smp_ready = 1'b1;
      respond(24'h09_0000, 1, 8'h42);
      wait_cmd();
      @(posedge clk); #1; enable = 1'b0;
      exp_smp_q.push_back({4'd9, tc(24'h7FFFFF)});
      respond(24'h7FFFFF, 0, 8'h00);
      chk("dis_smp_valid", smp_valid, 1);
      chk("dis_smp_data", smp_data, tc(24'h7FFFFF));
      chk("dis_busy", busy, 0);
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (spi_cmd_vld) n++;
      end
      chk("dis_no_cmd", n, 0);

      // Reset while waiting for a STATUS reply; the late reply is ignored.
      enable = 1'b1;
      exp_cmd_q.push_back(8'h40);
      wait_cmd();
      @(posedge clk); #1; rst = 1'b1; enable = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      chk_reset_outputs("midrst");
      spi_rd_data = 24'h03_0000; spi_rd_vld = 1'b1;
      @(posedge clk); #1; spi_rd_vld = 1'b0;
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (spi_cmd_vld || busy || smp_valid) n++;
      end
      chk("late_rd_ignored", n, 0);

      chk("cmd_queue_empty", exp_cmd_q.size(), 0);
      chk("smp_queue_empty", exp_smp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
